// File: rtl/CPU_package.sv
// Shared constants and types for the sequential shift-add multiplier.
package CPU_package;

    localparam int DATA_WIDTH = 8;
    localparam int CNT_WIDTH  = $clog2(DATA_WIDTH);

    // Value of the iteration counter on the final CALC cycle.
    localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/alu_seq_multiplier_if.sv
// Request/result bundle between a requester and the multiplier.
interface alu_seq_multiplier_if;
    import CPU_package::*;

    logic                    start;
    logic [DATA_WIDTH-1:0]   A;
    logic [DATA_WIDTH-1:0]   B;
    logic                    busy;
    logic                    done;
    logic [2*DATA_WIDTH-1:0] product;

    modport master (
        output start, A, B,
        input  busy, done, product
    );

    modport slave (
        input  start, A, B,
        output busy, done, product
    );

endinterface

// File: rtl/Full_Adder_by8.sv
// Ripple-carry adder used for the accumulate step of the multiplier.
module Full_Adder_by8
    import CPU_package::*;
(
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  cin,
    output logic [DATA_WIDTH-1:0] s,
    output logic                  cout
);

    logic [DATA_WIDTH:0] c;

    // Bitwise full-adder chain, carry rippling from LSB to MSB.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[DATA_WIDTH];

endmodule

// File: rtl/alu_seq_multiplier.sv
// Unsigned shift-add multiplier: one partial product per CALC cycle.
//
// state | meaning
// IDLE  | waiting for start; operands captured on accept
// CALC  | DATA_WIDTH add/shift iterations
// DONE  | product valid, done pulsed for one cycle
module alu_seq_multiplier
    import CPU_package::*;
(
    input  logic                clk,
    input  logic                rst,
    alu_seq_multiplier_if.slave bus
);

    mul_state_t              state;
    logic [DATA_WIDTH-1:0]   m;
    logic [DATA_WIDTH-1:0]   q;
    logic [DATA_WIDTH-1:0]   acc;
    logic [CNT_WIDTH-1:0]    count;
    logic [2*DATA_WIDTH-1:0] product;

    logic [DATA_WIDTH-1:0]   sum;
    logic                    cout;
    logic [DATA_WIDTH-1:0]   s_sel;
    logic                    c_sel;
    logic [DATA_WIDTH-1:0]   acc_next;
    logic [DATA_WIDTH-1:0]   q_next;

    Full_Adder_by8 u_add (
        .a    (acc),
        .b    (m),
        .cin  (1'b0),
        .s    (sum),
        .cout (cout)
    );

    // Select ACC+M or ACC by the multiplier LSB, then shift {C,S,Q} right.
    always_comb begin
        c_sel = 1'b0;
        s_sel = acc;
        if (q[0]) begin
            c_sel = cout;
            s_sel = sum;
        end
        acc_next = {c_sel, s_sel[DATA_WIDTH-1:1]};
        q_next   = {s_sel[0], q[DATA_WIDTH-1:1]};
    end

    // Sequencer and datapath registers; product only changes on the last CALC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            m       <= '0;
            q       <= '0;
            acc     <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        m     <= bus.A;
                        q     <= bus.B;
                        acc   <= '0;
                        count <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc   <= acc_next;
                    q     <= q_next;
                    count <= count + CNT_WIDTH'(1);
                    if (count == LAST_COUNT) begin
                        product <= {acc_next, q_next};
                        state   <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = (state != IDLE);
    assign bus.done    = (state == DONE);
    assign bus.product = product;

endmodule

// File: tb/tb_alu_seq_multiplier.sv
// Self-checking bench for alu_seq_multiplier: per-cycle reference model plus directed cases.
module tb_alu_seq_multiplier;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    alu_seq_multiplier_if bus ();

    alu_seq_multiplier dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a start seen in idle occupies the unit for 9 cycles,
    // the last of which shows done with product = A*B.
    int          rem;
    logic [15:0] pend;
    logic [15:0] exp_p;

    initial begin
        rem   = 0;
        pend  = '0;
        exp_p = '0;
    end

    always @(posedge clk) begin
        if (rst) begin
            rem   = 0;
            exp_p = '0;
        end else if (rem > 0) begin
            rem--;
            if (rem == 1) exp_p = pend;
        end else if (bus.start) begin
            pend = 16'(bus.A) * 16'(bus.B);
            rem  = 9;
        end
        #1;
        chk("model_busy",    32'(bus.busy),    32'(rem > 0));
        chk("model_done",    32'(bus.done),    32'(rem == 1));
        chk("model_product", 32'(bus.product), 32'(exp_p));
    end

    logic [15:0] p;
    int          lat;
    int          bcyc;
    int          ndone;

    // Issue one multiply and observe it on falling edges; k counts cycles after accept.
    task automatic run_mul(input logic [7:0] a, input logic [7:0] b, input bit scramble,
                           input bit hold_start,
                           output logic [15:0] prod, output int latency,
                           output int busy_cycles, output int dones);
        prod        = 'x;
        latency     = 0;
        busy_cycles = 0;
        dones       = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (!hold_start && k == 1) bus.start = 1'b0;
            if (scramble) begin
                bus.A = 8'($urandom);
                bus.B = 8'($urandom);
            end
            if (bus.busy) busy_cycles++;
            if (bus.done) begin
                dones++;
                if (latency == 0) latency = k;
                prod = bus.product;
                bus.start = 1'b0;
            end
            if (dones > 0 && !bus.busy) break;
        end
        bus.start = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy",    32'(bus.busy),    32'h0);
        chk("reset_done",    32'(bus.done),    32'h0);
        chk("reset_product", 32'(bus.product), 32'h0);
        rst = 1'b0;

        // Max operands: latency, busy length and full-width result.
        run_mul(8'hFF, 8'hFF, 1'b0, 1'b0, p, lat, bcyc, ndone);
        chk("ff_latency", 32'(lat),   32'd9);
        chk("ff_busy",    32'(bcyc),  32'd9);
        chk("ff_dones",   32'(ndone), 32'd1);
        chk("ff_product", 32'(p),     32'hFE01);

        run_mul(8'h00, 8'h5A, 1'b0, 1'b0, p, lat, bcyc, ndone);
        chk("zero_product", 32'(p), 32'h0000);
        run_mul(8'h0F, 8'h10, 1'b0, 1'b0, p, lat, bcyc, ndone);
        chk("0f10_product", 32'(p), 32'h00F0);
        run_mul(8'h80, 8'h02, 1'b0, 1'b0, p, lat, bcyc, ndone);
        chk("8002_product", 32'(p), 32'h0100);

        // Start held and operands forced to 1 during CALC must not disturb the result.
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 8'h12;
        bus.B     = 8'h34;
        ndone     = 0;
        p         = 'x;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            bus.A = 8'h01;
            bus.B = 8'h01;
            if (bus.done) begin
                ndone++;
                p = bus.product;
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        chk("hold_dones",   32'(ndone), 32'd1);
        chk("hold_product", 32'(p),     32'h03A8);

        // Reset mid-CALC aborts without done and clears the product at once.
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 8'hAA;
        bus.B     = 8'h55;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy",    32'(bus.busy),    32'h0);
        chk("abort_done",    32'(bus.done),    32'h0);
        chk("abort_product", 32'(bus.product), 32'h0);
        @(negedge clk);
        rst   = 1'b0;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);

        // Start during DONE is ignored; reasserting in the next idle cycle is taken.
        begin
            int first_k;
            int second_k;
            first_k  = 0;
            second_k = 0;
            @(negedge clk);
            bus.start = 1'b1;
            bus.A     = 8'h07;
            bus.B     = 8'h09;
            for (int k = 1; k <= 40; k++) begin
                @(negedge clk);
                if (k == 1) bus.start = 1'b0;
                if (bus.done) begin
                    if (first_k == 0) begin
                        first_k   = k;
                        bus.start = 1'b1;
                        bus.A     = 8'h0B;
                        bus.B     = 8'h0D;
                    end else if (second_k == 0) begin
                        second_k = k;
                        p        = bus.product;
                    end
                end
                if (first_k != 0 && k == first_k + 2) bus.start = 1'b0;
            end
            bus.start = 1'b0;
            chk("b2b_first",   32'(first_k),            32'd9);
            chk("b2b_spacing", 32'(second_k - first_k), 32'd10);
            chk("b2b_product", 32'(p),                  32'h008F);
        end

        // Randomized operands, with operand scrambling while busy.
        for (int n = 0; n < 1000; n++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (n < 4) begin
                ra = (n[0]) ? 8'hFF : 8'h00;
                rb = (n[1]) ? 8'hFF : 8'h01;
            end
            run_mul(ra, rb, ($urandom_range(0, 1) == 1), 1'b0, p, lat, bcyc, ndone);
            chk("rand_latency", 32'(lat), 32'd9);
            chk("rand_product", 32'(p),   32'(16'(ra) * 16'(rb)));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
